// File: rtl/reg_op_sequencer.sv
// Fetch/decode/execute sequencer for the 8085 register-group instructions
// (NOP, HLT, MOV r,r, MVI r,d8, INR r, DCR r) driving a register file port.
module reg_op_sequencer #(
    parameter logic [15:0] START_PC   = 16'h0000,
    parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [2:0]  read_addr1,
    input  logic [7:0]  read_data1,
    output logic        write_en,
    output logic [2:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        latch_is_mov,
    output logic [3:0]  flags,
    output logic [15:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned FW = 4;
    localparam logic [RW-1:0] REG_M = 3'b110;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_HLT,
        OP_MOV,
        OP_MVI,
        OP_INR,
        OP_DCR,
        OP_BAD
    } op_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  imm_q, imm_d;
    logic [FW-1:0]  flags_q, flags_d;
    logic [DW-1:0]  wait_q, wait_d;
    logic [RW-1:0]  rd_addr_q, rd_addr_d;
    logic [RW-1:0]  wr_addr_q, wr_addr_d;
    logic           bus_err_q, bus_err_d;

    logic [RW-1:0]  ddd;
    logic [RW-1:0]  sss;
    op_e            op_c;
    logic           bad_c;
    logic [DW-1:0]  result_c;
    logic           ac_c;

    assign ddd = ir_q[5:3];
    assign sss = ir_q[2:0];

    // Classify the latched opcode; bad_c covers unsupported and M-operand forms.
    always_comb begin
        op_c  = OP_BAD;
        bad_c = 1'b1;
        if (ir_q == 8'h00) begin
            op_c  = OP_NOP;
            bad_c = 1'b0;
        end else if (ir_q == 8'h76) begin
            op_c  = OP_HLT;
            bad_c = 1'b0;
        end else if (ir_q[7:6] == 2'b01) begin
            op_c  = OP_MOV;
            bad_c = (ddd == REG_M) || (sss == REG_M);
        end else if (ir_q[7:6] == 2'b00) begin
            case (sss)
                3'b110: begin
                    op_c  = OP_MVI;
                    bad_c = (ddd == REG_M);
                end
                3'b100: begin
                    op_c  = OP_INR;
                    bad_c = (ddd == REG_M);
                end
                3'b101: begin
                    op_c  = OP_DCR;
                    bad_c = (ddd == REG_M);
                end
                default: begin
                    op_c  = OP_BAD;
                    bad_c = 1'b1;
                end
            endcase
        end
    end

    // Result path goes straight through the register file read during EXEC.
    always_comb begin
        case (op_c)
            OP_MVI:  result_c = imm_q;
            OP_INR:  result_c = DW'(read_data1 + 8'd1);
            OP_DCR:  result_c = DW'(read_data1 - 8'd1);
            default: result_c = read_data1;
        endcase
        ac_c = (op_c == OP_INR) ? (read_data1[3:0] == 4'hF)
                                : (read_data1[3:0] != 4'h0);
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        flags_d   = flags_q;
        wait_d    = wait_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        bus_err_d = bus_err_q;

        case (state_q)
            S_FETCH, S_IMM: begin
                if (mem_ready) begin
                    pc_d   = AW'(pc_q + 16'd1);
                    wait_d = 8'd0;
                    if (state_q == S_FETCH) begin
                        ir_d    = mem_data;
                        state_d = S_DECODE;
                    end else begin
                        imm_d = mem_data;
                        // MVI M still consumes its byte but never writes.
                        if (bad_c) begin
                            state_d = S_FETCH;
                        end else begin
                            wr_addr_d = ddd;
                            state_d   = S_EXEC;
                        end
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = DW'(wait_q + 8'd1);
                end
            end

            S_DECODE: begin
                case (op_c)
                    OP_NOP: state_d = S_FETCH;
                    OP_HLT: state_d = S_HALT;
                    OP_MVI: state_d = S_IMM;
                    OP_MOV: begin
                        if (bad_c) begin
                            state_d = S_FETCH;
                        end else begin
                            rd_addr_d = sss;
                            wr_addr_d = ddd;
                            state_d   = S_EXEC;
                        end
                    end
                    OP_INR, OP_DCR: begin
                        if (bad_c) begin
                            state_d = S_FETCH;
                        end else begin
                            rd_addr_d = ddd;
                            wr_addr_d = ddd;
                            state_d   = S_EXEC;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_EXEC: begin
                if ((op_c == OP_INR) || (op_c == OP_DCR)) begin
                    flags_d = {result_c[7], (result_c == 8'h00), ac_c, ~^result_c};
                end
                state_d = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= START_PC;
            ir_q      <= 8'h00;
            imm_q     <= 8'h00;
            flags_q   <= 4'h0;
            wait_q    <= 8'd0;
            rd_addr_q <= 3'd0;
            wr_addr_q <= 3'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            flags_q   <= flags_d;
            wait_q    <= wait_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes are pure decodes of the state register.
    assign mem_rd       = (state_q == S_FETCH) || (state_q == S_IMM);
    assign mem_addr     = pc_q;
    assign write_en     = (state_q == S_EXEC);
    assign write_addr   = wr_addr_q;
    assign write_data   = write_en ? result_c : 8'h00;
    assign read_addr1   = rd_addr_q;
    assign illegal      = (state_q == S_DECODE) && bad_c;
    assign halted       = (state_q == S_HALT);
    assign latch_is_mov = 1'b0;
    assign flags        = flags_q;
    assign pc           = pc_q;
    assign bus_err      = bus_err_q;

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
Fetch/decode/execute sequencer for the 8085 register-group instructions (NOP, HLT, MOV r,r, MVI r,d8, INR r, DCR r). Sits directly upstream of the register file and drives its read/write address and write-data port. Reads opcode and immediate bytes from the memory interface, and computes results for INR and DCR with its own 8-bit incrementer/decrementer. Maintains the S, Z, AC and P flags for those ops.

Parameters:
START_PC, 16'h0000, PC value loaded on reset
WAIT_LIMIT, 8'd255, max cycles a memory read may wait for mem_ready before bus error

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
mem_data  in  8  memory read data, valid when mem_ready=1
mem_ready  in  1  memory read completion strobe
mem_rd  out  1  memory read request
mem_addr  out  16  memory read address (current PC)
read_addr1  out  3  register file source address
read_data1  in  8  register file source data (combinational)
write_en  out  1  register file write strobe (one cycle)
write_addr  out  3  register file destination address
write_data  out  8  register file write data
latch_is_mov  out  1  constant 0; all MOVs go through write_data
flags  out  4  {S,Z,AC,P}
pc  out  16  program counter
halted  out  1  HALT state indicator
illegal  out  1  one-cycle pulse on an unsupported or M-operand opcode
bus_err  out  1  sticky, set on a memory wait timeout

Behaviour:
- Reset (sync, checked first every edge, overrides any state including mid-fetch or EXEC):
  - pc=START_PC, state=FETCH, ir=0, imm=0, flags=0, wait_cnt=0.
  - write_en=0, mem_rd=0, illegal=0, bus_err=0, halted=0.
  - write_addr=0, write_data=0, read_addr1=0.
- States are FETCH, DECODE, IMM, EXEC and HALT.
- FETCH:
  - mem_rd=1, mem_addr=pc.
  - When mem_ready=1: ir<=mem_data, pc<=pc+1 (16-bit wrap FFFF->0000), wait_cnt<=0, go to DECODE.
  - Otherwise wait_cnt increments. If mem_ready is still 0 when wait_cnt==WAIT_LIMIT: bus_err<=1, go to HALT.
- DECODE (mem_rd=0). ir = b7..b0, with DDD=ir[5:3] and SSS=ir[2:0]. Registers are B0 C1 D2 E3 H4 L5 M6 A7.
  - 8'h00 NOP: go to FETCH.
  - 8'h76 HLT: go to HALT.
  - 01DDDSSS MOV: if DDD or SSS is 110, pulse illegal and go to FETCH. Otherwise read_addr1<=SSS and go to EXEC.
  - 00DDD110 MVI: if DDD=110, pulse illegal, then still go to IMM to consume the byte and suppress the write. Otherwise go to IMM.
  - 00DDD100 INR / 00DDD101 DCR: if DDD=110, pulse illegal and go to FETCH. Otherwise read_addr1<=DDD and go to EXEC.
  - Any other opcode: pulse illegal, go to FETCH.
- IMM: same handshake and timeout as FETCH. On mem_ready: imm<=mem_data, pc<=pc+1, go to EXEC.
- EXEC: one cycle. write_en=1, write_addr=DDD, then go to FETCH. write_data depends on the op:
  - MOV: read_data1.
  - MVI: imm.
  - INR: read_data1+1, mod 256.
  - DCR: read_data1-1, mod 256.
- Flags on INR/DCR only, registered in EXEC:
  - S=result[7].
  - Z=(result==0).
  - P=even parity of result (~^result).
  - AC: INR sets it when src[3:0]==4'hF. DCR sets it when src[3:0]!=4'h0 (8085 borrow-complement).
  - MOV, MVI and NOP leave flags unchanged.
- write_en, illegal and mem_rd are never asserted in the same cycle as each other, except that illegal for MVI M is asserted in DECODE.
- HALT: halted=1, all strobes 0, pc frozen. Only rst exits.
- Latency:
  - MOV/INR/DCR: 3 cycles plus memory wait (FETCH, DECODE, EXEC).
  - MVI: 4 cycles plus memory wait for each of its two reads.
- latch_is_mov tied 0 in every state.

Test Plan:
- Memory {06 3C, 78, 00} with zero-wait ready: MVI B,3C, then MOV A,B. Required: write addr0 data 3C at cycle 4; write addr7 data 3C at cycle 7; pc=0004 after NOP.
- Register B=FF, opcode 04 (INR B): write_data=00, flags S0 Z1 AC1 P1. Then 05 (DCR B) with B=00: write_data=FF, flags S1 Z0 AC0 P1.
- Opcode 76 after reset: halted=1 within 2 cycles, pc=0001 and stable for 20 cycles, no further mem_rd. Assert rst: pc=START_PC, halted=0.
- Opcodes 7E (MOV A,M), then 36 55 (MVI M), then 27 (unsupported):
  - illegal pulses three times, no write_en.
  - pc advances 1, 2 and 1 respectively.
- mem_ready held low with WAIT_LIMIT=4: bus_err=1 and halted=1 exactly after the limit. Assert rst mid-wait in a second run: clean restart at FETCH.
- pc preloaded FFFF via START_PC, opcode 00: pc wraps to 0000, next mem_addr=0000.
